// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_e : sequencer state (LOAD = boot loader owns i_mem, RUN = fetching)
//   NOP           : canonical RV32 no-op encoding (addi x0, x0, 0)
//   QDEPTH        : depth of the fetch return queue
package fetch_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          QDEPTH = 2;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of {pc, instr} pairs returned from i_mem.
// The head always sits in entry 0 so the outputs come straight from flops.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               drop every held entry (takes priority over push)
//   push, push_pc/instr write one entry
//   pop                 consume the head (caller guarantees count != 0)
//   count               number of held entries (0..2)
//   head_valid/pc/instr current head
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  input  logic            pop,
  output logic [1:0]      count,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr
);

  logic [XLEN-1:0] pc_reg    [QDEPTH];
  logic [31:0]     instr_reg [QDEPTH];
  logic [XLEN-1:0] pc_next   [QDEPTH];
  logic [31:0]     instr_next[QDEPTH];
  logic [1:0]      count_reg;
  logic [1:0]      count_next;
  logic [1:0]      wpos;
  logic            do_push;

  assign do_push = push & ~flush;
  // A simultaneous pop shifts the queue first, so the new word lands one slot lower.
  assign wpos    = count_reg - {1'b0, pop};

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      pc_next[i]    = pc_reg[i];
      instr_next[i] = instr_reg[i];
    end
    for (int i = 0; i < QDEPTH - 1; i++) begin
      if (pop) begin
        pc_next[i]    = pc_reg[i+1];
        instr_next[i] = instr_reg[i+1];
      end
    end
    for (int i = 0; i < QDEPTH; i++) begin
      if (do_push && wpos == 2'(i)) begin
        pc_next[i]    = push_pc;
        instr_next[i] = push_instr;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case ({do_push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pc_reg[gi]    <= '0;
        instr_reg[gi] <= '0;
      end else begin
        pc_reg[gi]    <= pc_next[gi];
        instr_reg[gi] <= instr_next[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_reg <= 2'd0;
    else      count_reg <= count_next;
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head_pc    = pc_reg[0];
  assign head_instr = instr_reg[0];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-memory sequencer for the fetch stage.
// Owns the PC, issues one-cycle-latency reads to i_mem, buffers returned
// words in fetch_buf, and handles execute redirects. In LOAD the i_mem write
// port belongs to the boot loader; ld_done switches to RUN.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    taken branch/jump from execute
//   dec_ready                      decode accepts the presented word
//   if_valid, if_pc, if_instr      queue head towards decode
//   imem_rd_addr / imem_rd_dout    i_mem read port (registered read)
//   imem_wr_addr/_din, imem_we     i_mem write port (loader pass-through)
//   ld_valid, ld_addr, ld_data     loader word
//   ld_ready                       loader accepted (LOAD only)
//   ld_done                        end of program load
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 10,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              dec_ready,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] imem_rd_addr,
  input  logic [31:0]       imem_rd_dout,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_din,
  output logic              imem_we,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              ld_done
);

  fetch_state_e    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            inflight_reg;
  logic [XLEN-1:0] inflight_pc_reg;

  logic            run;
  logic            pop;
  logic            redirect;
  logic            issue;
  logic            push;
  logic [1:0]      count;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] issue_pc;

  assign run      = (state_reg == RUN);
  assign pop      = if_valid & dec_ready;
  assign redirect = run & redirect_valid;

  // Words that will be held once this cycle's push/pop settle; issuing only
  // below 2 guarantees the response always finds a free slot.
  assign occupancy = 3'(count) + 3'(inflight_reg) - 3'(pop);
  assign issue     = run & (redirect | (occupancy < 3'd2));
  // A redirect kills the response arriving this cycle.
  assign push      = run & inflight_reg & ~redirect;

  // Redirect targets are word aligned: low two bits are forced to zero.
  assign issue_pc     = redirect ? (redirect_pc & ~XLEN'(3)) : pc_reg;
  assign imem_rd_addr = issue_pc[ADDR_W+1:2];

  // Write enable is gated by reset so it drops the instant reset asserts.
  assign imem_we      = rst & ~run & ld_valid;
  assign imem_wr_addr = ld_addr;
  assign imem_wr_din  = ld_data;
  assign ld_ready     = ~run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= BOOT_LOAD ? LOAD : RUN;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (ld_done) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
          end
        end
        RUN: begin
          inflight_reg <= issue;
          if (issue) begin
            inflight_pc_reg <= issue_pc;
            pc_reg          <= issue_pc + XLEN'(4);
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  fetch_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_pc    (inflight_pc_reg),
    .push_instr (imem_rd_dout),
    .pop        (pop),
    .count      (count),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a behavioural i_mem
// (registered read, synchronous write). Every check uses hand-computed values.
module tb_fetch_ctrl;

  localparam int NLD = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [9:0]  imem_rd_addr;
  logic [31:0] imem_rd_dout;
  logic [9:0]  imem_wr_addr;
  logic [31:0] imem_wr_din;
  logic        imem_we;
  logic        ld_valid;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];
  logic [9:0]  lda [NLD];
  logic [31:0] ldd [NLD];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) mem[imem_wr_addr] <= imem_wr_din;
    imem_rd_dout <= mem[imem_rd_addr];
  end

  fetch_ctrl #(
    .XLEN      (32),
    .ADDR_W    (10),
    .RESET_PC  (32'h0000_0000),
    .BOOT_LOAD (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_dout   (imem_rd_dout),
    .imem_wr_addr   (imem_wr_addr),
    .imem_wr_din    (imem_wr_din),
    .imem_we        (imem_we),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .ld_done        (ld_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    $display("[%0t] %s if_valid=%0b if_pc=%h if_instr=%h", $time, tag, if_valid, if_pc, if_instr);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"}, if_pc, p);
      chk({tag, ".instr"}, if_instr, i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    lda = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
            10'h010, 10'h011, 10'h012, 10'h3FE, 10'h3FF};
    ldd = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66,
            32'hA0, 32'hA1, 32'hA2, 32'hFE, 32'hFF};

    // Reset with a loader word pending: nothing may be written.
    rst = 1'b0; ld_valid = 1'b1; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    #2;
    head("reset", 1'b0, 32'h0, 32'h0);
    chk("reset.if_pc", if_pc, 32'h0);
    chk("reset.if_instr", if_instr, 32'h0);
    chk("reset.ld_ready", 32'(ld_ready), 32'h1);
    chk("reset.imem_we", 32'(imem_we), 32'h0);
    ld_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Program load; the last word goes together with ld_done.
    for (int k = 0; k < NLD; k++) begin
      ld_valid = 1'b1; ld_addr = lda[k]; ld_data = ldd[k]; ld_done = (k == NLD - 1);
      #1;
      $display("[%0t] load addr=%h data=%h done=%0b", $time, lda[k], ldd[k], ld_done);
      chk("load.we", 32'(imem_we), 32'h1);
      chk("load.wr_addr", 32'(imem_wr_addr), 32'(lda[k]));
      tick();
    end

    // R0: first RUN cycle, loader ignored, read of word 0 issues.
    ld_done = 1'b0;
    #1;
    chk("r0.ld_ready", 32'(ld_ready), 32'h0);
    chk("r0.we_ignored", 32'(imem_we), 32'h0);
    chk("r0.rd_addr", 32'(imem_rd_addr), 32'h0);
    head("r0", 1'b0, 32'h0, 32'h0);
    ld_valid = 1'b0;
    tick(); head("r1", 1'b0, 32'h0, 32'h0);
    tick(); head("r2", 1'b1, 32'h0, 32'h11);
    tick(); head("r3", 1'b1, 32'h4, 32'h22);
    tick(); head("r4", 1'b1, 32'h8, 32'h33);
    dec_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick(); head("stall", 1'b1, 32'h8, 32'h33);
    end
    tick(); head("r9", 1'b1, 32'h8, 32'h33);
    dec_ready = 1'b1;
    tick(); head("r10", 1'b1, 32'hC, 32'h44);
    tick(); head("r11", 1'b1, 32'h10, 32'h55);

    // Redirect while stalled with a read inflight.
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1; chk("r11.rd_addr", 32'(imem_rd_addr), 32'h10);
    tick(); redirect_valid = 1'b0;
    head("r12", 1'b0, 32'h0, 32'h0);
    tick(); head("r13", 1'b1, 32'h40, 32'hA0);
    tick(); head("r14", 1'b1, 32'h40, 32'hA0);

    // Queue now full; redirect coincides with a pop.
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1; chk("r14.rd_addr", 32'(imem_rd_addr), 32'h10);
    tick(); redirect_valid = 1'b0;
    head("r15", 1'b0, 32'h0, 32'h0);
    tick(); head("r16", 1'b1, 32'h40, 32'hA0);
    tick(); head("r17", 1'b1, 32'h44, 32'hA1);
    tick(); head("r18", 1'b1, 32'h48, 32'hA2);

    // Address wrap at the memory size.
    redirect_valid = 1'b1; redirect_pc = 32'hFF8;
    #1; chk("r18.rd_addr", 32'(imem_rd_addr), 32'h3FE);
    tick(); redirect_valid = 1'b0;
    head("r19", 1'b0, 32'h0, 32'h0);
    tick(); head("r20", 1'b1, 32'hFF8, 32'hFE);
    tick(); head("r21", 1'b1, 32'hFFC, 32'hFF);
    tick(); head("r22", 1'b1, 32'h1000, 32'h11);

    // PC wrap at 2^32, misaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    #1; chk("r22.rd_addr", 32'(imem_rd_addr), 32'h3FE);
    tick(); redirect_valid = 1'b0;
    head("r23", 1'b0, 32'h0, 32'h0);
    tick(); head("r24", 1'b1, 32'hFFFF_FFF8, 32'hFE);
    tick(); head("r25", 1'b1, 32'hFFFF_FFFC, 32'hFF);
    tick(); head("r26", 1'b1, 32'h0, 32'h11);
    tick(); head("r27", 1'b1, 32'h4, 32'h22);

    // Reset mid-stream.
    rst = 1'b0;
    #1;
    head("rst_run", 1'b0, 32'h0, 32'h0);
    chk("rst_run.if_pc", if_pc, 32'h0);
    chk("rst_run.ld_ready", 32'(ld_ready), 32'h1);
    tick(); rst = 1'b1;

    // Reset in LOAD while a loader word is being written.
    tick();
    ld_valid = 1'b1; ld_addr = 10'h020; ld_data = 32'h5A;
    #1; chk("ld.we_before_rst", 32'(imem_we), 32'h1);
    rst = 1'b0;
    #1; chk("ld.we_in_rst", 32'(imem_we), 32'h0);
    ld_valid = 1'b0;
    tick(); rst = 1'b1;
    tick(); ld_done = 1'b1;
    tick(); ld_done = 1'b0;
    #1; chk("restart.rd_addr", 32'(imem_rd_addr), 32'h0);
    tick(); head("restart1", 1'b0, 32'h0, 32'h0);
    tick(); head("restart2", 1'b1, 32'h0, 32'h11);
    tick(); head("restart3", 1'b1, 32'h4, 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction memory inside the fetch stage. Owns the PC, issues one-cycle-latency reads to `i_mem`, and buffers returned words in a 2-entry queue so decode backpressure never loses an instruction. Handles taken-branch/jump redirects by discarding stale words. Before execution starts, it shares the `i_mem` write port with a boot loader.

## Interface
Parameters:
- XLEN, 32, PC/data width
- ADDR_W, 10, `i_mem` word-address width
- RESET_PC, 32'h0000_0000, first fetch address
- BOOT_LOAD, 1, 1 = start in LOAD state, 0 = start in RUN

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- redirect_valid  in  1  branch/jump redirect from execute
- redirect_pc  in  XLEN  redirect target
- dec_ready  in  1  decode accepts the current instruction
- if_valid  out  1  if_pc/if_instr valid
- if_pc  out  XLEN  PC of the presented instruction
- if_instr  out  32  instruction word
- imem_rd_addr  out  ADDR_W  to `i_mem` rd_addr0
- imem_rd_dout  in  32  from `i_mem` rd_dout0
- imem_wr_addr  out  ADDR_W  to `i_mem` wr_addr0
- imem_wr_din  out  32  to `i_mem` wr_din0
- imem_we  out  1  to `i_mem` we0
- ld_valid  in  1  loader word valid
- ld_addr  in  ADDR_W  loader word address
- ld_data  in  32  loader word
- ld_ready  out  1  loader accepted (LOAD state only)
- ld_done  in  1  end of program load

## Operation
- States: LOAD, RUN. Reset enters LOAD if BOOT_LOAD=1, otherwise RUN.
- LOAD:
  - ld_ready=1.
  - When ld_valid=1: imem_we=1, imem_wr_addr=ld_addr, imem_wr_din=ld_data.
  - No reads are issued; if_valid=0.
  - ld_done=1 → RUN, with pc=RESET_PC. If ld_valid and ld_done are high in the same cycle, the word is written and the state still moves to RUN.
- RUN:
  - ld_ready=0, imem_we=0; ld_valid is ignored.
  - Address: imem_rd_addr = pc[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so the address wraps modulo the memory size.
  - PC increments by 4 modulo 2^XLEN; FFFF_FFFC wraps to 0.
  - Issue rule: issue when (queue count + inflight − pop) < 2, where pop = if_valid & dec_ready.
  - Inflight is a 1-bit flag. In the cycle after an issue, imem_rd_dout and the issued PC are pushed into the queue.
  - Outputs: if_valid/if_pc/if_instr always show the queue head.
- Redirect (redirect_valid=1 in cycle N):
  - The queue is flushed and any inflight response is dropped.
  - imem_rd_addr = redirect_pc[ADDR_W+1:2] is driven combinationally in cycle N (the read issues in N).
  - pc ← redirect_pc + 4.
  - Redirect overrides pop, stall and the issue rule. redirect_pc[1:0] is treated as 0.
- redirect_valid in LOAD: ignored.

## Timing
- Reset values:
  - if_valid=0, if_pc=0, if_instr=0
  - imem_we=0, inflight=0, queue empty
  - pc=RESET_PC
  - ld_ready=BOOT_LOAD
- Entering RUN: the first read issues in the first RUN cycle; if_valid rises 2 cycles later.
- Redirect→if_valid latency: 2 cycles (redirect in N, target presented in N+2).
- Throughput: 1 instruction/cycle while dec_ready=1.
- Stall (dec_ready=0): at most 2 words are held, the head is stable, and no word is lost or duplicated.
- Queue full with an inflight response: not possible, because the issue rule prevents it.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). An inflight read is discarded.

## Structure
- Package `fetch_pkg`:
  - state enum {LOAD, RUN}
  - NOP constant 32'h0000_0013
  - queue depth constant 2
- Sub-module `fetch_buf`: 2-entry FIFO of {pc, instr} with push, pop, flush, count.

## Test plan
- BOOT_LOAD=1: load words 0..3 = 0x11,0x22,0x33,0x44, then pulse ld_done → if_pc 0,4,8,C with matching instructions on consecutive cycles; first if_valid 2 cycles after RUN entry.
- dec_ready=0 for 5 cycles during streaming → head holds at pc=8, at most 2 words buffered; on release, 8 then C follow with no gap or duplicate.
- Redirect to 0x40 while the queue is full and a read is inflight → next if_valid shows pc=0x40 exactly 2 cycles later; 0xC/0x10 are never presented.
- Redirect coincides with pop → popped word is consumed, remainder flushed, 0x40 follows.
- pc=0xFFC with ADDR_W=10 → next pc 0x1000 reads word 0; pc=0xFFFF_FFFC wraps to 0.
- Reset asserted mid-stream and in LOAD with ld_valid=1 → if_valid and imem_we fall immediately; restart from RESET_PC.
